// File: rtl/arb_n_rr_lock.sv
// Registered round-robin arbiter with grant lock and optional hold timeout.
// Define ARB_HOLD_TIMEOUT_EN to bound ownership to HOLD_MAX busy cycles.
module arb_n_rr_lock #(
  parameter int REQ_WIDTH = 16,
  parameter int IDX_W     = $clog2(REQ_WIDTH),
  parameter int HOLD_MAX  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_WIDTH-1:0] req,
  output logic [REQ_WIDTH-1:0] grant,
  output logic                 grant_vld,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 hold_expired
);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t               r_state;
  state_t               w_nxt_state;
  logic [REQ_WIDTH-1:0] r_grant;
  logic [REQ_WIDTH-1:0] w_nxt_grant;
  logic [REQ_WIDTH-1:0] w_own_oh;
  logic [REQ_WIDTH-1:0] w_others;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_nxt_idx;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     w_nxt_ptr;
  logic [IDX_W-1:0]     w_ptr_inc;
  logic                 r_vld;
  logic                 w_timeout;
  logic                 w_new_grant;
  logic                 w_idle_hit;
  logic                 w_rel_hit;
  logic [IDX_W-1:0]     w_idle_win;
  logic [IDX_W-1:0]     w_rel_win;

  // First set bit of v, searching from p upward with wrap.
  function automatic logic [IDX_W:0] f_pick(
    input logic [REQ_WIDTH-1:0] v,
    input logic [IDX_W-1:0]     p
  );
    logic             hit;
    logic [IDX_W-1:0] win;
    hit = 1'b0;
    win = '0;
    for (int k = 0; k < REQ_WIDTH; k++) begin
      int j;
      j = int'(p) + k;
      if (j >= REQ_WIDTH) j = j - REQ_WIDTH;
      if (!hit && v[IDX_W'(j)]) begin
        hit = 1'b1;
        win = IDX_W'(j);
      end
    end
    return {hit, win};
  endfunction

  assign w_own_oh  = REQ_WIDTH'(1) << r_idx;
  assign w_others  = req & ~w_own_oh;
  assign w_ptr_inc = (r_idx == IDX_W'(REQ_WIDTH-1)) ?
                     '0 : r_idx + 1'b1;

  assign {w_idle_hit, w_idle_win} = f_pick(req, r_ptr);
  assign {w_rel_hit, w_rel_win}   = f_pick(w_others, w_ptr_inc);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = r_grant;
    w_nxt_idx   = r_idx;
    w_nxt_ptr   = r_ptr;
    w_new_grant = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_idle_hit) begin
          w_nxt_grant = REQ_WIDTH'(1) << w_idle_win;
          w_nxt_idx   = w_idle_win;
          w_nxt_state = ST_BUSY;
          w_new_grant = 1'b1;
        end
      end
      ST_BUSY: begin
        // Owner release or forced release both rotate past the owner.
        if (!req[r_idx] || w_timeout) begin
          w_nxt_ptr = w_ptr_inc;
          if (w_rel_hit) begin
            w_nxt_grant = REQ_WIDTH'(1) << w_rel_win;
            w_nxt_idx   = w_rel_win;
            w_new_grant = 1'b1;
          end else begin
            w_nxt_grant = '0;
            w_nxt_idx   = '0;
            w_nxt_state = ST_IDLE;
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_grant = '0;
        w_nxt_idx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_vld   <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_grant <= w_nxt_grant;
      r_vld   <= |w_nxt_grant;
      r_idx   <= w_nxt_idx;
      r_ptr   <= w_nxt_ptr;
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX+1);
  localparam logic [CNT_W-1:0] LP_LIM = CNT_W'(HOLD_MAX-1);

  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_hexp;

  assign w_timeout = (r_state == ST_BUSY) &&
                     (r_hold_cnt == LP_LIM) &&
                     req[r_idx] && (|w_others);

  // Saturates at the limit so a late competitor forces release at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_hexp     <= 1'b0;
    end else begin
      r_hexp <= w_timeout;
      if (w_new_grant) begin
        r_hold_cnt <= '0;
      end else if (r_state == ST_BUSY &&
                   r_hold_cnt != LP_LIM) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign hold_expired = r_hexp;
`else
  logic w_unused_hold;

  assign w_timeout     = 1'b0;
  assign w_unused_hold = w_new_grant | (HOLD_MAX < 1);
  assign hold_expired  = 1'b0;
`endif

  assign grant     = r_grant;
  assign grant_vld = r_vld;
  assign grant_idx = r_idx;

endmodule

// File: tb/tb_arb_n_rr_lock.sv
// Scoreboard bench for arb_n_rr_lock, REQ_WIDTH=4, HOLD_MAX=4.
// Expectations follow ARB_HOLD_TIMEOUT_EN when it is defined.
module tb_arb_n_rr_lock;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  grant;
  logic          grant_vld;
  logic [IW-1:0] grant_idx;
  logic          hold_expired;

  arb_n_rr_lock #(
    .REQ_WIDTH(N),
    .HOLD_MAX (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_vld   (grant_vld),
    .grant_idx   (grant_idx),
    .hold_expired(hold_expired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic         h;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] f_idx(input logic [N-1:0] g);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (g[i]) r = IW'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("grant", 32'(grant), 32'(e.g));
      chk("grant_vld", 32'(grant_vld), 32'(|e.g));
      chk("grant_idx", 32'(grant_idx), 32'(f_idx(e.g)));
      chk("hold_expired", 32'(hold_expired), 32'(e.h));
    end
  end

  task automatic step(input logic [N-1:0] r,
                      input logic [N-1:0] g,
                      input logic h = 1'b0);
    exp_t e;
    @(negedge clk);
    req = r;
    e.g = g;
    e.h = h;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_vld", 32'(grant_vld), 32'h0);
    chk("rst_idx", 32'(grant_idx), 32'h0);
    chk("rst_hexp", 32'(hold_expired), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-busy reset must also return ptr to 0.
    step(4'b0100, 4'b0100);
    step(4'b0000, 4'b0000);
    step(4'b1000, 4'b1000);
    step(4'b1000, 4'b1000);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_vld", 32'(grant_vld), 32'h0);
    chk("mid_rst_idx", 32'(grant_idx), 32'h0);
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    step(4'b1010, 4'b0010);
    step(4'b1010, 4'b0010);

    do_reset();
    step(4'b1111, 4'b0001);
    step(4'b1110, 4'b0010);
    step(4'b1101, 4'b0100);
    step(4'b1011, 4'b1000);
    step(4'b0111, 4'b0001);

    step(4'b1110, 4'b0010);
`ifdef ARB_HOLD_TIMEOUT_EN
    repeat (3) step(4'b1111, 4'b0010);
    step(4'b1111, 4'b0100, 1'b1);
    repeat (3) step(4'b1111, 4'b0100);
    step(4'b1111, 4'b1000, 1'b1);
    repeat (2) step(4'b1111, 4'b1000);
`else
    repeat (10) step(4'b1111, 4'b0010);
`endif

    step(4'b0000, 4'b0000);
    step(4'b0100, 4'b0100);
    step(4'b0000, 4'b0000);
    step(4'b0101, 4'b0001);
    step(4'b0101, 4'b0001);
    step(4'b0100, 4'b0100);

    step(4'b1000, 4'b1000);
    step(4'b0000, 4'b0000);
    step(4'b1111, 4'b0001);
    step(4'b1110, 4'b0010);
    step(4'b0000, 4'b0000);

    for (int i = 0; i < 20; i++)
      step(4'b0001, 4'b0001);
`ifdef ARB_HOLD_TIMEOUT_EN
    step(4'b0011, 4'b0010, 1'b1);
`else
    step(4'b0011, 4'b0001);
`endif
    step(4'b0000, 4'b0000);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
